// File: rtl/uart_cmd_parser.sv
// Pulls bytes from an RX FIFO and parses HEADER, CMD, LEN, payload, CSUM frames.
// Good frames update cmd/len/payload; bad or stalled frames pulse pkt_err with a cause code.
module uart_cmd_parser #(
    parameter logic [7:0] HEADER      = 8'hAA,
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_dout,
    output logic        fifo_rd_en,
    output logic [7:0]  cmd,
    output logic [3:0]  len,
    output logic [63:0] payload,
    output logic        pkt_valid,
    output logic        pkt_err,
    output logic [1:0]  err_code,
    output logic        busy
);
    localparam int            TW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // The error pulse is registered, so firing here places it TIMEOUT_CYC cycles after the last byte.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 2);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [1:0]    ERR_SUM   = 2'd1;
    localparam logic [1:0]    ERR_LEN   = 2'd2;
    localparam logic [1:0]    ERR_TMO   = 2'd3;

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          rd_pend_q, rd_pend_d;
    logic [7:0]    sum_q, sum_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    wlen_q, wlen_d;
    logic [7:0]    wcmd_q, wcmd_d;
    logic [63:0]   wbuf_q, wbuf_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [3:0]    len_q, len_d;
    logic [63:0]   payload_q, payload_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          pkt_err_q, pkt_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          byte_vld_s;
    logic          tmo_hit_s;

    assign byte_vld_s = rd_pend_q;
    assign fifo_rd_en = !rst && !fifo_empty && !rd_pend_q;
    assign tmo_hit_s  = (state_q != S_HDR) && (tmo_q == TMO_LAST);

    assign cmd       = cmd_q;
    assign len       = len_q;
    assign payload   = payload_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign busy      = (state_q != S_HDR);

    // Frame parser next-state, working frame and result updates.
    always_comb begin
        state_d     = state_q;
        rd_pend_d   = fifo_rd_en;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        wlen_d      = wlen_q;
        wcmd_d      = wcmd_q;
        wbuf_d      = wbuf_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        payload_d   = payload_q;
        pkt_valid_d = 1'b0;
        pkt_err_d   = 1'b0;
        err_code_d  = err_code_q;

        if (byte_vld_s) begin
            tmo_d = '0;
            case (state_q)
                S_HDR: begin
                    if (fifo_dout == HEADER) begin
                        state_d = S_CMD;
                    end else begin
                        state_d = S_HDR;
                    end
                end
                S_CMD: begin
                    wcmd_d  = fifo_dout;
                    sum_d   = fifo_dout;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    sum_d  = sum_q + fifo_dout;
                    wbuf_d = 64'd0;
                    cnt_d  = 4'd0;
                    wlen_d = fifo_dout[3:0];
                    if (fifo_dout > MAX_LEN_B) begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = S_HDR;
                    end else if (fifo_dout == 8'd0) begin
                        state_d = S_SUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    wbuf_d[{cnt_q[2:0], 3'b000} +: 8] = fifo_dout;
                    sum_d = sum_q + fifo_dout;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == (wlen_q - 4'd1)) begin
                        state_d = S_SUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_SUM: begin
                    if (fifo_dout == sum_q) begin
                        cmd_d       = wcmd_q;
                        len_d       = wlen_q;
                        payload_d   = wbuf_q;
                        pkt_valid_d = 1'b1;
                    end else begin
                        pkt_err_d  = 1'b1;
                        err_code_d = ERR_SUM;
                    end
                    state_d = S_HDR;
                end
                default: begin
                    state_d = S_HDR;
                end
            endcase
        end else if (state_q != S_HDR) begin
            if (tmo_hit_s) begin
                pkt_err_d  = 1'b1;
                err_code_d = ERR_TMO;
                state_d    = S_HDR;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= S_HDR;
            rd_pend_q   <= 1'b0;
            sum_q       <= 8'd0;
            cnt_q       <= 4'd0;
            wlen_q      <= 4'd0;
            wcmd_q      <= 8'd0;
            wbuf_q      <= 64'd0;
            tmo_q       <= '0;
            cmd_q       <= 8'd0;
            len_q       <= 4'd0;
            payload_q   <= 64'd0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            wlen_q      <= wlen_d;
            wcmd_q      <= wcmd_d;
            wbuf_q      <= wbuf_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            payload_q   <= payload_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_err_q   <= pkt_err_d;
            err_code_q  <= err_code_d;
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: a byte FIFO feeds the parser while a frame-level model predicts outputs.
module tb_uart_cmd_parser;
    localparam int         TMO  = 100;
    localparam int         MAXL = 8;
    localparam logic [7:0] HDR  = 8'hAA;

    logic        clk_in     = 1'b0;
    logic        rst        = 1'b1;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_dout  = 8'h00;
    logic        fifo_rd_en;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
    logic        pkt_valid;
    logic        pkt_err;
    logic [1:0]  err_code;
    logic        busy;

    uart_cmd_parser #(.HEADER(HDR), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
        .clk_in(clk_in), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .cmd(cmd), .len(len), .payload(payload),
        .pkt_valid(pkt_valid), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
    );

    always #5 clk_in = ~clk_in;

    logic [7:0]  src[$];
    logic [7:0]  fifo[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          rst_req = 1'b1;
    bit          vld_c = 1'b0;
    logic [7:0]  byte_c = 8'h00;
    int          n_pv = 0, n_pe = 0, n_consumed = 0, last_vld_cyc = 0, last_err_gap = -1;

    // Frame-level model: bytes collected since a header, plus idle time since the last byte.
    logic [7:0]  m_frm[$];
    int          m_idle = 0;
    logic [7:0]  e_cmd = 8'h00;
    logic [3:0]  e_len = 4'h0;
    logic [63:0] e_payload = 64'h0;
    logic        e_pv = 1'b0, e_pe = 1'b0, e_busy = 1'b0;
    logic [1:0]  e_ec = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic m_raise(input logic [1:0] c);
        e_pe = 1'b1;
        e_ec = c;
        m_frm.delete();
    endtask

    task automatic m_frame();
        int n;
        int s;
        int flen;
        n = m_frm.size();
        s = 0;
        if (n >= 3) begin
            flen = int'(m_frm[2]);
            if (flen > MAXL) begin
                m_raise(2'd2);
            end else if (n == flen + 4) begin
                for (int i = 1; i < n - 1; i++) s += int'(m_frm[i]);
                if ((s % 256) == int'(m_frm[n-1])) begin
                    e_cmd     = m_frm[1];
                    e_len     = 4'(flen);
                    e_payload = 64'h0;
                    for (int k = 0; k < flen; k++) e_payload[8*k +: 8] = m_frm[3+k];
                    e_pv = 1'b1;
                    m_frm.delete();
                end else begin
                    m_raise(2'd1);
                end
            end
        end
    endtask

    task automatic m_step(input bit r, input bit v, input logic [7:0] b);
        if (r) begin
            m_frm.delete();
            m_idle = 0;
            e_cmd = 8'h00; e_len = 4'h0; e_payload = 64'h0;
            e_pv = 1'b0; e_pe = 1'b0; e_ec = 2'd0; e_busy = 1'b0;
        end else begin
            e_pv = 1'b0;
            e_pe = 1'b0;
            if (v) begin
                m_idle = 0;
                if (m_frm.size() == 0) begin
                    if (b == HDR) m_frm.push_back(b);
                end else begin
                    m_frm.push_back(b);
                    m_frame();
                end
            end else if (m_frm.size() > 0) begin
                m_idle++;
                if (m_idle == TMO - 1) m_raise(2'd3);
            end
            e_busy = (m_frm.size() > 0);
        end
    endtask

    // One clock cycle: drive inputs, compare, advance model and FIFO.
    task automatic step();
        bit exp_rd;
        @(negedge clk_in);
        rst        = rst_req;
        fifo_empty = (fifo.size() == 0);
        #1;
        exp_rd = !rst && !fifo_empty && !vld_c;
        chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        chk("rd_while_empty", 64'(fifo_rd_en & fifo_empty), 64'd0);
        chk("pkt_valid", 64'(pkt_valid), 64'(e_pv));
        chk("pkt_err", 64'(pkt_err), 64'(e_pe));
        chk("valid_err_excl", 64'(pkt_valid & pkt_err), 64'd0);
        chk("err_code", 64'(err_code), 64'(e_ec));
        chk("cmd", 64'(cmd), 64'(e_cmd));
        chk("len", 64'(len), 64'(e_len));
        chk("payload", payload, e_payload);
        chk("busy", 64'(busy), 64'(e_busy));
        if (pkt_valid === 1'b1) n_pv++;
        if (pkt_err === 1'b1) begin
            n_pe++;
            last_err_gap = cyc - last_vld_cyc;
        end
        m_step(rst, vld_c, byte_c);
        if (vld_c && !rst) begin
            n_consumed++;
            last_vld_cyc = cyc;
        end
        if (fifo_rd_en === 1'b1 && fifo.size() > 0) begin
            fifo_dout = fifo.pop_front();
            vld_c = 1'b1;
        end else begin
            vld_c = 1'b0;
        end
        byte_c = fifo_dout;
        if (src.size() > 0 && $urandom_range(0, 3) != 0) fifo.push_back(src.pop_front());
        cyc++;
    endtask

    task automatic feed(input logic [95:0] v, input int n);
        for (int i = 0; i < n; i++) src.push_back(v[8*(n-1-i) +: 8]);
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while ((src.size() > 0 || fifo.size() > 0 || vld_c) && guard < 3000) begin
            step();
            guard++;
        end
        if (guard >= 3000) chk("drain_bound", 64'd1, 64'd0);
        repeat (extra) step();
    endtask

    task automatic gen_frame(input int kind);
        logic [7:0] c;
        logic [7:0] d;
        int l, s, cut;
        logic [7:0] fr[$];
        c = 8'($urandom);
        l = $urandom_range(0, MAXL);
        fr.push_back(HDR); fr.push_back(c); fr.push_back(8'(l));
        s = int'(c) + l;
        for (int k = 0; k < l; k++) begin
            d = 8'($urandom);
            fr.push_back(d);
            s += int'(d);
        end
        if (kind == 5) fr.push_back(8'(s + $urandom_range(1, 255)));
        else fr.push_back(8'(s));
        if (kind == 6) begin
            fr.delete();
            fr.push_back(HDR); fr.push_back(c); fr.push_back(8'($urandom_range(MAXL + 1, 255)));
        end
        if (kind == 7) begin
            fr.delete();
            repeat ($urandom_range(1, 4)) fr.push_back(8'($urandom));
        end
        if (kind == 8) begin
            cut = $urandom_range(1, fr.size() - 1);
            while (fr.size() > cut) void'(fr.pop_back());
        end
        if (kind == 9) begin
            cut = $urandom_range(1, fr.size() - 1);
            for (int i = 0; i < cut; i++) src.push_back(fr[i]);
            drain(0);
            repeat ($urandom_range(TMO - 8, TMO + 4)) step();
            for (int i = cut; i < fr.size(); i++) src.push_back(fr[i]);
        end else begin
            foreach (fr[i]) src.push_back(fr[i]);
        end
        drain((kind == 8) ? TMO + 20 : 4);
    endtask

    initial begin
        #5000000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int pv0, pe0, base, guard;
        rst_req = 1'b1;
        repeat (3) step();
        rst_req = 1'b0;
        step();
        chk("reset_cmd", 64'(cmd), 64'h0);
        chk("reset_payload", payload, 64'h0);
        chk("reset_busy_err", 64'({busy, err_code, pkt_valid, pkt_err}), 64'h0);

        pv0 = n_pv; pe0 = n_pe;
        feed(96'hAA_01_02_10_20_33, 6);
        drain(4);
        chk("t1_pulses", 64'({n_pv - pv0, n_pe - pe0}), {32'd1, 32'd0});
        chk("t1_cmd_len", 64'({cmd, len}), 64'h012);
        chk("t1_payload", payload, 64'h2010);

        pe0 = n_pe;
        feed(96'hAA_01_02_10_20_34, 6);
        drain(4);
        chk("t2_err", 64'({n_pe - pe0, 30'd0, err_code}), {32'd1, 32'd1});
        chk("t2_hold", 64'({cmd, len}), 64'h012);
        chk("t2_hold_payload", payload, 64'h2010);
        pv0 = n_pv;
        feed(96'hAA_FF_01_02_02, 5);
        drain(4);
        chk("t2_wrap", 64'({n_pv - pv0, 20'd0, cmd, len}), {32'd1, 32'hFF1});
        chk("t2_payload", payload, 64'h02);

        pe0 = n_pe;
        feed(96'hAA_05_09, 3);
        drain(4);
        chk("t3_len_err", 64'({n_pe - pe0, 29'd0, busy, err_code}), {32'd1, 32'd2});
        feed(96'hAA_02_00_02, 4);
        drain(4);
        chk("t3_zero_len", 64'({cmd, len}), 64'h020);
        chk("t3_payload", payload, 64'h0);

        pv0 = n_pv; pe0 = n_pe;
        feed(96'h00_FF_55_AA_03_01_7E_82, 8);
        drain(4);
        chk("t4_pulses", 64'({n_pv - pv0, n_pe - pe0}), {32'd1, 32'd0});
        chk("t4_cmd_len", 64'({cmd, len}), 64'h031);
        chk("t4_payload", payload, 64'h7E);

        pe0 = n_pe;
        feed(96'hAA_01, 2);
        drain(TMO + 10);
        chk("t5_tmo", 64'({n_pe - pe0, 30'd0, err_code}), {32'd1, 32'd3});
        chk("t5_tmo_gap", 64'(last_err_gap), 64'(TMO));

        src.push_back(HDR); src.push_back(8'h10); src.push_back(8'h08);
        for (int k = 0; k < 8; k++) src.push_back(8'(k + 1));
        src.push_back(8'h3C);
        base = n_consumed;
        guard = 0;
        while (n_consumed < base + 6 && guard < 500) begin
            step();
            guard++;
        end
        chk("t6_reach", 64'(guard < 500), 64'd1);
        rst_req = 1'b1;
        repeat (3) step();
        src.delete();
        fifo.delete();
        rst_req = 1'b0;
        repeat (3) step();
        chk("t6_rst_out", 64'({cmd, len, busy, err_code}), 64'h0);
        chk("t6_rst_payload", payload, 64'h0);
        feed(96'hAA_10_03_01_02_03_19, 7);
        drain(4);
        chk("t6_cmd_len", 64'({cmd, len}), 64'h103);
        chk("t6_payload", payload, 64'h030201);

        for (int it = 0; it < 80; it++) gen_frame($urandom_range(0, 9));
        drain(TMO + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
